branch_resolve: RTL and testbench
=================================

Name: branch_resolve

Overview:
- Execute-stage branch resolution unit, directly downstream of the branch comparator; consumes its taken flag (br_en_i).
- Static not-taken prediction. Computes the branch/jump target and link address, decides whether fetch must be redirected, flushes the younger instructions, and holds a redirect request until the fetch stage / L1 I-cache accepts it.
- Stalls execute while a redirect is pending.

Parameters:
- XLEN, 32, datapath and address width
- FLUSH_CYCLES, 1, cycles flush_o stays high per redirect (>=1)

Ports:
- clk  in  1  clock, rising edge
- rst_n  in  1  reset, asynchronous, active-low
- ex_valid_i  in  1  execute-stage instruction valid
- ex_kind_i  in  2  br_kind_t: BK_NONE=0, BK_BRANCH=1, BK_JAL=2, BK_JALR=3
- ex_pc_i  in  XLEN  PC of execute instruction
- ex_imm_i  in  XLEN  sign-extended immediate
- ex_rs1_i  in  XLEN  rs1 operand (JALR base)
- br_en_i  in  1  comparator result for BK_BRANCH
- redir_ready_i  in  1  fetch accepts redirect
- redir_valid_o  out  1  redirect request
- redir_pc_o  out  XLEN  redirect target
- flush_o  out  1  kill IF/ID instructions
- stall_o  out  1  hold execute stage
- link_pc_o  out  XLEN  registered PC+4 of last accepted jump
- misalign_o  out  1  one-cycle pulse, target not word-aligned

Behaviour:
- Reset (rst_n low, async) forces:
  - state IDLE
  - all outputs 0; redir_pc_o=0, link_pc_o=0
  - flush counter 0
- Accept: ex_valid_i && !stall_o.
- taken = JAL | JALR | (BRANCH & br_en_i). BK_NONE is never taken.
- Target:
  - BRANCH/JAL: pc+imm
  - JALR: (rs1+imm) & ~1
  - All arithmetic mod 2^XLEN; wrap-around silent.
- link_pc_o: loaded with pc+4 on an accepted JAL/JALR; otherwise holds.
- FSM IDLE:
  - Accepted taken, target[1:0]==0 -> next cycle redir_valid_o=1, redir_pc_o=target, flush_o=1 for FLUSH_CYCLES cycles; state WAIT.
  - Accepted taken, target[1:0]!=0 -> misalign_o=1 for the next cycle only; no redirect, no flush; stay IDLE.
  - Not taken -> nothing.
- FSM WAIT:
  - redir_valid_o=1; redir_pc_o stable until handshake.
  - stall_o = !redir_ready_i (combinational).
  - Handshake: redir_valid_o & redir_ready_i -> state IDLE; redir_valid_o=0 next cycle.
  - redir_ready_i already high on the first WAIT cycle -> one-cycle redirect.
- Latency: accept to redir_valid_o = 1 cycle.
- ex inputs while stall_o=1 are ignored; upstream must hold them stable.
- Handshake cycle with stall_o=0 and a new taken instruction accepted -> WAIT re-entered directly with the new target; flush restarts.
- flush_o counter is independent of the handshake; a fast ready does not shorten the flush.
- rst_n low mid-WAIT: redirect dropped immediately; no residual flush after release.
- X on br_en_i is ignored unless ex_kind_i==BK_BRANCH.

Optional Feature:
- Macro BRANCH_RESOLVE_STATS_EN.
- Defined:
  - Adds outputs stat_branches_o[31:0] (accepted BK_BRANCH) and stat_taken_o[31:0] (accepted taken BRANCH/JAL/JALR, misaligned included).
  - Both counters saturate at 0xFFFFFFFF and reset to 0.
- Undefined: ports and counters absent; behaviour otherwise identical.

Decomposition:
- rv32i_types package:
  - br_kind_t enum and its encodings
  - brres_state_t {IDLE, WAIT}
  - constant PC_STEP=4
- Sub-module branch_target_calc: combinational target, link and misalign computation from kind/pc/imm/rs1. The FSM, flush counter and stats stay in branch_resolve.

Test Plan:
- BK_BRANCH, pc=0x100, imm=0x20, br_en_i=1, redir_ready_i=1 -> next cycle redir_valid_o=1, redir_pc_o=0x120, flush_o=1 one cycle; idle after.
- BK_BRANCH, br_en_i=0 -> no redirect, no flush, stall_o stays 0.
- BK_JALR, rs1=0x2003, imm=0x4, pc=0x40, ready low 3 cycles -> redir_pc_o=0x2006 & ~1 → 0x2006 misaligned check: [1:0]=2 -> misalign_o pulse, no redirect. Repeat with rs1=0x2001 -> target 0x2004, stall_o=1 for 3 cycles, link_pc_o=0x44.
- BK_JAL, pc=0xFFFFFFF8, imm=0x10 -> redir_pc_o=0x00000008 (wrap).
- Assert rst_n=0 during WAIT -> redir_valid_o, flush_o, stall_o drop to 0 asynchronously; IDLE after release.
- With BRANCH_RESOLVE_STATS_EN: 5 branches (2 taken) + 1 JAL -> stat_branches_o=5, stat_taken_o=3.

Source files
------------

// File: rtl/rv32i_types.sv
// rtl/rv32i_types.sv - shared RV32I execute-stage types for branch resolution
// Contents:
//   br_kind_t     : control-transfer kind decoded upstream
//   brres_state_t : redirect handshake state
//   PC_STEP       : sequential instruction stride (link address offset)
package rv32i_types;

  typedef enum logic [1:0] {
    BK_NONE   = 2'd0,
    BK_BRANCH = 2'd1,
    BK_JAL    = 2'd2,
    BK_JALR   = 2'd3
  } br_kind_t;

  typedef enum logic {
    IDLE = 1'b0,
    WAIT = 1'b1
  } brres_state_t;

  localparam int PC_STEP = 4;

endpackage

// File: rtl/branch_target_calc.sv
// rtl/branch_target_calc.sv - combinational target, link and misalign decode
// Ports:
//   kind     in  br_kind_t  control-transfer kind
//   pc       in  XLEN       PC of the instruction
//   imm      in  XLEN       sign-extended immediate
//   rs1      in  XLEN       JALR base register
//   br_en    in  1          comparator result, only meaningful for BK_BRANCH
//   taken    out 1          instruction transfers control
//   target   out XLEN       destination address (mod 2^XLEN)
//   link     out XLEN       return address pc+4
//   misalign out 1          target is not word-aligned
module branch_target_calc
  import rv32i_types::*;
#(
  parameter int XLEN = 32
) (
  input  br_kind_t        kind,
  input  logic [XLEN-1:0] pc,
  input  logic [XLEN-1:0] imm,
  input  logic [XLEN-1:0] rs1,
  input  logic            br_en,
  output logic            taken,
  output logic [XLEN-1:0] target,
  output logic [XLEN-1:0] link,
  output logic            misalign
);

  localparam logic [XLEN-1:0] LSB_CLR = ~{{(XLEN-1){1'b0}}, 1'b1};

  always_comb begin
    taken  = 1'b0;
    target = pc + imm;
    // br_en is only consulted for conditional branches so an X on it
    // cannot leak into jumps or non-control instructions.
    unique case (kind)
      BK_BRANCH: taken = br_en;
      BK_JAL:    taken = 1'b1;
      BK_JALR: begin
        taken  = 1'b1;
        target = (rs1 + imm) & LSB_CLR;
      end
      default:   taken = 1'b0;
    endcase
  end

  assign link     = pc + XLEN'(PC_STEP);
  assign misalign = |target[1:0];

endmodule

// File: rtl/branch_resolve.sv
// rtl/branch_resolve.sv - execute-stage branch resolution and fetch redirect
// Optional macro BRANCH_RESOLVE_STATS_EN adds stat_branches_o/stat_taken_o.
// Ports:
//   clk, rst_n        clock, async active-low reset
//   ex_valid_i        execute instruction valid
//   ex_kind_i         br_kind_t encoding
//   ex_pc_i/imm/rs1   operands for target computation
//   br_en_i           comparator taken flag
//   redir_ready_i     fetch accepts redirect
//   redir_valid_o/pc  redirect request and target
//   flush_o           kill younger IF/ID instructions
//   stall_o           hold execute while a redirect is not yet accepted
//   link_pc_o         pc+4 of the last accepted jump
//   misalign_o        one-cycle pulse on a misaligned taken target
//   stat_*_o          (stats build) saturating branch / taken counters
module branch_resolve
  import rv32i_types::*;
#(
  parameter int XLEN         = 32,
  parameter int FLUSH_CYCLES = 1
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            ex_valid_i,
  input  logic [1:0]      ex_kind_i,
  input  logic [XLEN-1:0] ex_pc_i,
  input  logic [XLEN-1:0] ex_imm_i,
  input  logic [XLEN-1:0] ex_rs1_i,
  input  logic            br_en_i,
  input  logic            redir_ready_i,
  output logic            redir_valid_o,
  output logic [XLEN-1:0] redir_pc_o,
  output logic            flush_o,
  output logic            stall_o,
  output logic [XLEN-1:0] link_pc_o,
  output logic            misalign_o
`ifdef BRANCH_RESOLVE_STATS_EN
  ,
  output logic [31:0]     stat_branches_o,
  output logic [31:0]     stat_taken_o
`endif
);

  localparam int CNT_W = $clog2(FLUSH_CYCLES + 1);

  brres_state_t    state;
  logic [CNT_W-1:0] flush_cnt;
  br_kind_t        kind;
  logic            taken;
  logic            tgt_misalign;
  logic [XLEN-1:0] target;
  logic [XLEN-1:0] link;
  logic            accept;
  logic            redirect;
  logic            is_jump;

  assign kind = br_kind_t'(ex_kind_i);

  branch_target_calc #(.XLEN(XLEN)) u_calc (
    .kind     (kind),
    .pc       (ex_pc_i),
    .imm      (ex_imm_i),
    .rs1      (ex_rs1_i),
    .br_en    (br_en_i),
    .taken    (taken),
    .target   (target),
    .link     (link),
    .misalign (tgt_misalign)
  );

  assign redir_valid_o = (state == WAIT);
  // Ready in the same cycle completes the handshake, so execute may proceed.
  assign stall_o       = redir_valid_o & ~redir_ready_i;
  assign flush_o       = (flush_cnt != '0);
  assign accept        = ex_valid_i & ~stall_o;
  assign redirect      = accept & taken & ~tgt_misalign;
  assign is_jump       = (kind == BK_JAL) || (kind == BK_JALR);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      redir_pc_o <= '0;
      flush_cnt  <= '0;
      link_pc_o  <= '0;
      misalign_o <= 1'b0;
    end else begin
      misalign_o <= accept & taken & tgt_misalign;
      if (accept && is_jump) begin
        link_pc_o <= link;
      end
      // A new redirect wins over handshake completion and restarts the flush;
      // otherwise the flush counter drains regardless of the handshake.
      if (redirect) begin
        state      <= WAIT;
        redir_pc_o <= target;
        flush_cnt  <= CNT_W'(FLUSH_CYCLES);
      end else begin
        if (state == WAIT && redir_ready_i) begin
          state <= IDLE;
        end
        if (flush_cnt != '0) begin
          flush_cnt <= flush_cnt - CNT_W'(1);
        end
      end
    end
  end

`ifdef BRANCH_RESOLVE_STATS_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stat_branches_o <= '0;
      stat_taken_o    <= '0;
    end else begin
      if (accept && kind == BK_BRANCH && stat_branches_o != '1) begin
        stat_branches_o <= stat_branches_o + 32'd1;
      end
      if (accept && taken && stat_taken_o != '1) begin
        stat_taken_o <= stat_taken_o + 32'd1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_branch_resolve.sv
// tb/tb_branch_resolve.sv - self-checking bench for branch_resolve
module tb_branch_resolve;

  localparam int FC = 1;

  logic        clk;
  logic        rst_n;
  logic        ex_valid_i;
  logic [1:0]  ex_kind_i;
  logic [31:0] ex_pc_i;
  logic [31:0] ex_imm_i;
  logic [31:0] ex_rs1_i;
  logic        br_en_i;
  logic        redir_ready_i;
  logic        redir_valid_o;
  logic [31:0] redir_pc_o;
  logic        flush_o;
  logic        stall_o;
  logic [31:0] link_pc_o;
  logic        misalign_o;
`ifdef BRANCH_RESOLVE_STATS_EN
  logic [31:0] stat_branches_o;
  logic [31:0] stat_taken_o;
`endif

  branch_resolve #(.XLEN(32), .FLUSH_CYCLES(FC)) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .ex_valid_i    (ex_valid_i),
    .ex_kind_i     (ex_kind_i),
    .ex_pc_i       (ex_pc_i),
    .ex_imm_i      (ex_imm_i),
    .ex_rs1_i      (ex_rs1_i),
    .br_en_i       (br_en_i),
    .redir_ready_i (redir_ready_i),
    .redir_valid_o (redir_valid_o),
    .redir_pc_o    (redir_pc_o),
    .flush_o       (flush_o),
    .stall_o       (stall_o),
    .link_pc_o     (link_pc_o),
    .misalign_o    (misalign_o)
`ifdef BRANCH_RESOLVE_STATS_EN
    ,
    .stat_branches_o (stat_branches_o),
    .stat_taken_o    (stat_taken_o)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;
  bit chk_en = 1'b0;

  // Reference state: a pending redirect (target), remaining flush cycles,
  // last link address, misalign pulse and event counts.
  bit          m_pending;
  logic [31:0] m_target;
  int          m_flush_left;
  logic [31:0] m_link;
  bit          m_mis;
  longint      m_nbr;
  longint      m_ntk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic void model_reset();
    m_pending = 0; m_target = 0; m_flush_left = 0; m_link = 0; m_mis = 0;
    m_nbr = 0; m_ntk = 0;
  endfunction

  function automatic bit model_stall();
    return m_pending && !redir_ready_i;
  endfunction

  // One clock of the reference: decide what the instruction presented this
  // cycle does to the redirect/flush/link bookkeeping.
  function automatic void model_step();
    bit acc, tk, handshake;
    logic [31:0] tgt;
    if (!rst_n) begin
      model_reset();
      return;
    end
    acc = ex_valid_i && !model_stall();
    tk  = acc && (ex_kind_i == 2 || ex_kind_i == 3 || (ex_kind_i == 1 && br_en_i));
    if (ex_kind_i == 3) tgt = (ex_rs1_i + ex_imm_i) & 32'hFFFF_FFFE;
    else                tgt = ex_pc_i + ex_imm_i;
    handshake = m_pending && redir_ready_i;
    if (acc && ex_kind_i >= 2) m_link = ex_pc_i + 32'd4;
    if (acc && ex_kind_i == 1 && m_nbr < 64'hFFFF_FFFF) m_nbr++;
    if (tk && m_ntk < 64'hFFFF_FFFF) m_ntk++;
    m_mis = tk && (tgt % 4 != 0);
    if (tk && (tgt % 4 == 0)) begin
      m_pending    = 1;
      m_target     = tgt;
      m_flush_left = FC;
    end else begin
      if (handshake) m_pending = 0;
      if (m_flush_left > 0) m_flush_left--;
    end
  endfunction

  always @(negedge clk) begin
    if (chk_en) begin
      chk("redir_valid", {31'd0, redir_valid_o}, {31'd0, m_pending});
      if (m_pending) chk("redir_pc", redir_pc_o, m_target);
      chk("flush", {31'd0, flush_o}, {31'd0, m_flush_left > 0});
      chk("stall", {31'd0, stall_o}, {31'd0, model_stall()});
      chk("link_pc", link_pc_o, m_link);
      chk("misalign", {31'd0, misalign_o}, {31'd0, m_mis});
`ifdef BRANCH_RESOLVE_STATS_EN
      chk("stat_branches", stat_branches_o, m_nbr[31:0]);
      chk("stat_taken", stat_taken_o, m_ntk[31:0]);
`endif
    end
  end

  task automatic set_in(input bit v, input logic [1:0] k, input logic [31:0] pc,
                        input logic [31:0] imm, input logic [31:0] rs1,
                        input bit br, input bit rdy);
    ex_valid_i = v; ex_kind_i = k; ex_pc_i = pc; ex_imm_i = imm;
    ex_rs1_i = rs1; br_en_i = br; redir_ready_i = rdy;
  endtask

  task automatic tick();
    @(posedge clk);
    model_step();
    #1;
  endtask

  task automatic pulse_reset();
    #1;
    rst_n = 1'b0;
    model_reset();
    @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  initial begin
    logic [31:0] r;
    set_in(0, 0, 0, 0, 0, 0, 0);
    rst_n = 1'b0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    chk("rst_redir_valid", {31'd0, redir_valid_o}, 32'd0);
    chk("rst_redir_pc", redir_pc_o, 32'd0);
    chk("rst_flush", {31'd0, flush_o}, 32'd0);
    chk("rst_stall", {31'd0, stall_o}, 32'd0);
    chk("rst_link", link_pc_o, 32'd0);
    chk("rst_misalign", {31'd0, misalign_o}, 32'd0);
    chk_en = 1'b1;
    rst_n  = 1'b1;

    // Taken branch with immediate ready: one-cycle redirect and flush.
    set_in(1, 1, 32'h100, 32'h20, 0, 1, 1);
    tick();
    chk("br_valid", {31'd0, redir_valid_o}, 32'd1);
    chk("br_pc", redir_pc_o, 32'h120);
    chk("br_model_pc", m_target, 32'h120);
    chk("br_flush", {31'd0, flush_o}, 32'd1);
    chk("br_stall", {31'd0, stall_o}, 32'd0);
    set_in(0, 0, 0, 0, 0, 0, 1);
    tick();
    chk("br_done_valid", {31'd0, redir_valid_o}, 32'd0);
    chk("br_done_flush", {31'd0, flush_o}, 32'd0);

    // Not-taken branch: nothing happens.
    set_in(1, 1, 32'h100, 32'h20, 0, 0, 0);
    tick();
    chk("nt_valid", {31'd0, redir_valid_o}, 32'd0);
    chk("nt_flush", {31'd0, flush_o}, 32'd0);
    chk("nt_stall", {31'd0, stall_o}, 32'd0);

    // JALR to 0x2006: misaligned pulse, no redirect, link still updated.
    set_in(1, 3, 32'h40, 32'h4, 32'h2003, 0, 0);
    tick();
    chk("mis_pulse", {31'd0, misalign_o}, 32'd1);
    chk("mis_valid", {31'd0, redir_valid_o}, 32'd0);
    chk("mis_flush", {31'd0, flush_o}, 32'd0);
    chk("mis_link", link_pc_o, 32'h44);
    set_in(0, 0, 0, 0, 0, 0, 0);
    tick();
    chk("mis_pulse_end", {31'd0, misalign_o}, 32'd0);

    // JALR to 0x2004 with ready low for three cycles.
    set_in(1, 3, 32'h40, 32'h4, 32'h2001, 0, 0);
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("jalr_stall", {31'd0, stall_o}, 32'd1);
      chk("jalr_pc", redir_pc_o, 32'h2004);
    end
    chk("jalr_link", link_pc_o, 32'h44);
    set_in(0, 0, 0, 0, 0, 0, 1);
    #1;
    chk("jalr_ready_unstall", {31'd0, stall_o}, 32'd0);
    tick();
    chk("jalr_done", {31'd0, redir_valid_o}, 32'd0);

    // JAL wrapping past 2^32, then reset in the middle of WAIT.
    set_in(1, 2, 32'hFFFF_FFF8, 32'h10, 0, 0, 0);
    tick();
    chk("wrap_pc", redir_pc_o, 32'h0000_0008);
    chk("wrap_link", link_pc_o, 32'hFFFF_FFFC);
    chk("wrap_stall", {31'd0, stall_o}, 32'd1);
    set_in(0, 0, 0, 0, 0, 0, 0);
    #1;
    rst_n = 1'b0;
    model_reset();
    #1;
    chk("arst_valid", {31'd0, redir_valid_o}, 32'd0);
    chk("arst_flush", {31'd0, flush_o}, 32'd0);
    chk("arst_stall", {31'd0, stall_o}, 32'd0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    tick();
    chk("arst_idle", {31'd0, redir_valid_o}, 32'd0);
    chk("arst_noflush", {31'd0, flush_o}, 32'd0);

    // Five branches (two taken) plus one JAL, back to back with ready high.
    pulse_reset();
    for (int i = 0; i < 5; i++) begin
      set_in(1, 1, 32'h200, 32'h8, 0, (i == 0 || i == 2), 1);
      tick();
    end
    set_in(1, 2, 32'h300, 32'h40, 0, 0, 1);
    tick();
    set_in(0, 0, 0, 0, 0, 0, 1);
    tick();
    chk("model_nbr", m_nbr[31:0], 32'd5);
    chk("model_ntk", m_ntk[31:0], 32'd3);
`ifdef BRANCH_RESOLVE_STATS_EN
    chk("stat_branches_lit", stat_branches_o, 32'd5);
    chk("stat_taken_lit", stat_taken_o, 32'd3);
`endif

    // Random traffic; execute inputs are held while the model says stalled.
    for (int n = 0; n < 3000; n++) begin
      redir_ready_i = ($urandom_range(0, 2) != 0);
      if (!model_stall()) begin
        ex_valid_i = ($urandom_range(0, 3) != 0);
        r = $urandom;
        ex_kind_i = r[1:0];
        ex_pc_i   = $urandom & 32'hFFFF_FFFC;
        ex_imm_i  = ($urandom_range(0, 3) == 0) ? $urandom : ($urandom & 32'hFFFF_FFFC);
        ex_rs1_i  = ($urandom_range(0, 3) == 0) ? $urandom : ($urandom & 32'hFFFF_FFFC);
        br_en_i   = r[2];
      end
      if ($urandom_range(0, 499) == 0) begin
        rst_n = 1'b0;
        model_reset();
        #1;
        chk("rnd_arst_valid", {31'd0, redir_valid_o}, 32'd0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
      end else begin
        tick();
      end
    end

    chk_en = 1'b0;
    @(posedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
